// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// The optional zero-latency fall-through is enabled by defining FD_QUEUE_BYPASS_EN.
package fd_pkg;

    localparam int FD_XLEN = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP
    localparam logic [FD_XLEN-1:0] FD_NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [FD_XLEN-1:0] inst;
        logic [FD_XLEN-1:0] pc;
    } fd_entry_t;

endpackage

// File: rtl/fd_queue_ctrl.sv
// Pointer/occupancy control for fd_inst_queue: handshakes, push/pop enables, indices.
// With FD_QUEUE_BYPASS_EN, a push into an empty queue consumed in the same cycle is not written.
module fd_queue_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          push_en,
    output logic          pop_en,
    output logic [PW-1:0] wr_idx,
    output logic [PW-1:0] rd_idx,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;

    // in_ready looks only at registered occupancy, so a full queue never accepts
    // a push even when the head is being popped in the same cycle.
    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);

`ifdef FD_QUEUE_BYPASS_EN
    logic bypass_take;
    assign bypass_take = (cnt == '0) & in_valid & out_ready & ~flush;
    assign push_en     = in_valid & in_ready & ~flush & ~bypass_take;
`else
    assign push_en     = in_valid & in_ready & ~flush;
`endif
    assign pop_en      = out_valid & out_ready & ~flush;

    assign wr_idx = wptr;
    assign rd_idx = rptr;
    assign count  = cnt;

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_en) wptr <= wptr + PTR_ONE;
            if (pop_en)  rptr <= rptr + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fd_inst_queue.sv
// Elastic fetch-to-decode buffer holding up to DEPTH {inst, pc} entries in FIFO order.
// Define FD_QUEUE_BYPASS_EN for a combinational fall-through when the queue is empty.
module fd_inst_queue
    import fd_pkg::*;
#(
    parameter int              XLEN     = FD_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_INST = FD_NOP_INST
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_inst,
    output logic [XLEN-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic          push_en;
    logic          pop_en;
    logic          q_valid;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    fd_entry_t mem [DEPTH];
    fd_entry_t head;

    fd_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (q_valid),
        .push_en   (push_en),
        .pop_en    (pop_en),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .count     (count)
    );

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_idx] <= '{inst: in_inst, pc: in_pc};
        end
    end

    assign head = mem[rd_idx];

    always_comb begin
        out_valid = q_valid;
        out_inst  = NOP_INST;
        out_pc    = '0;
        if (q_valid) begin
            out_inst = head.inst;
            out_pc   = head.pc;
        end
`ifdef FD_QUEUE_BYPASS_EN
        else if (in_valid && !flush) begin
            out_valid = 1'b1;
            out_inst  = in_inst;
            out_pc    = in_pc;
        end
`endif
    end

endmodule

// File: tb/tb_fd_inst_queue.sv
// Self-checking bench for fd_inst_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_fd_inst_queue;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef FD_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            nrst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [CW-1:0]   count;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model: each element is {inst, pc}, front is the head.
    logic [63:0] mq [$];

    fd_inst_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instOf(input logic [31:0] pc);
        return pc ^ 32'hC0DE0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, return 2ns after it.
    task automatic applyStimulus(input bit v, input logic [31:0] pc, input bit rdy,
                                 input bit fl, input bit rst_n = 1'b1);
        nrst      = rst_n;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = instOf(pc);
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    // Model update: apply the queue rules to the inputs sampled at this edge.
    always @(posedge clk) begin : model_update
        int n;
        bit byp, do_pop, do_push;
        if (!nrst) begin
            mq.delete();
            check_en <= 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            n       = mq.size();
            byp     = BYP && (n == 0) && in_valid && out_ready;
            do_pop  = (n > 0) && out_ready;
            do_push = in_valid && (n < DEPTH) && !byp;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({in_inst, in_pc});
        end
    end

    // Every-cycle comparison of all outputs against the model, mid-cycle.
    always @(negedge clk) begin : compare
        int          n;
        logic        e_valid;
        logic [31:0] e_inst, e_pc;
        if (check_en) begin
            n       = mq.size();
            e_valid = 1'b0;
            e_inst  = NOP;
            e_pc    = '0;
            if (n > 0) begin
                e_valid = 1'b1;
                e_inst  = mq[0][63:32];
                e_pc    = mq[0][31:0];
            end else if (BYP && in_valid && !flush) begin
                e_valid = 1'b1;
                e_inst  = in_inst;
                e_pc    = in_pc;
            end
            checkOutput("m_out_valid", 64'(out_valid), 64'(e_valid));
            checkOutput("m_out_inst",  64'(out_inst),  64'(e_inst));
            checkOutput("m_out_pc",    64'(out_pc),    64'(e_pc));
            checkOutput("m_in_ready",  64'(in_ready),  64'(n != DEPTH));
            checkOutput("m_count",     64'(count),     64'(n));
        end
    end

    initial begin
        logic [31:0] pc;
        nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Reset state
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_inst",  64'(out_inst),  64'h13);
        checkOutput("rst_out_pc",    64'(out_pc),    64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_count",     64'(count),     64'd0);

        // Fill to capacity, then an ignored fifth push
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'h100 + 32'(4 * i), 0, 0);
        checkOutput("full_count",    64'(count),    64'd4);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1, 32'h110, 0, 0);
        checkOutput("full_ignored_count", 64'(count), 64'd4);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_pc",   64'(out_pc),   64'(32'h100 + 32'(4 * i)));
            checkOutput("drain_inst", 64'(out_inst), 64'(instOf(32'h100 + 32'(4 * i))));
            applyStimulus(0, 0, 1, 0);
        end
        checkOutput("drained_valid", 64'(out_valid), 64'd0);

        // Streaming with both sides always ready; pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            pc = 32'h400 + 32'(4 * i);
            applyStimulus(1, pc, 1, 0);
            checkOutput("stream_count", 64'(count),  BYP ? 64'd0 : 64'd1);
            checkOutput("stream_pc",    64'(out_pc), 64'(pc));
        end
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);

        // Flush with three entries held and a simultaneous push
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h500 + 32'(4 * i), 0, 0);
        checkOutput("preflush_count", 64'(count), 64'd3);
        applyStimulus(1, 32'h200, 0, 1);
        checkOutput("flush_count",     64'(count),     64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_out_inst",  64'(out_inst),  64'h13);
        applyStimulus(0, 0, 1, 0);
        checkOutput("postflush_valid", 64'(out_valid), 64'd0);

        // Full queue: pop and push offered together -> pop only
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'h600 + 32'(4 * i), 0, 0);
        applyStimulus(1, 32'h610, 1, 0);
        checkOutput("fullpop_count", 64'(count), 64'd3);
        for (int i = 1; i < DEPTH; i++) begin
            checkOutput("fullpop_pc", 64'(out_pc), 64'(32'h600 + 32'(4 * i)));
            applyStimulus(0, 0, 1, 0);
        end
        checkOutput("fullpop_empty", 64'(count), 64'd0);

`ifdef FD_QUEUE_BYPASS_EN
        // Zero-latency fall-through on an empty queue
        in_valid = 1'b1; in_pc = 32'h300; in_inst = instOf(32'h300); out_ready = 1'b1;
        #1;
        checkOutput("byp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("byp_out_pc",    64'(out_pc),    64'h300);
        @(posedge clk);
        #2;
        checkOutput("byp_count", 64'(count), 64'd0);
        applyStimulus(0, 0, 1, 0);
`endif

        // Randomized traffic: fill-biased phase, then drain-biased phase
        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            bit v, r, f, rn;
            v  = ($urandom_range(3) != 0);
            r  = (i < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            f  = ($urandom_range(23) == 0);
            rn = ($urandom_range(79) != 0);
            applyStimulus(v, pc, r, f, rn);
            pc = pc + 32'd4;
        end
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fd_inst_queue.md
Name: fd_inst_queue

Overview:
Parametrised elastic fetch-to-decode buffer that replaces the single-entry F/D pipeline register. It holds up to DEPTH fetched instructions with their PCs. Fetch and decode are decoupled by valid/ready handshakes, so a decode stall no longer freezes fetch immediately. Flush discards all buffered entries, and NOP_INST is presented on the output whenever no valid entry exists.

Parameters:
XLEN, 32, width of the instruction and PC fields
DEPTH, 4, number of entries; power of two, >= 2
NOP_INST, 32'h00000013, instruction word driven on out_inst when out_valid=0

Ports:
clk  input  1  clock
nrst  input  1  reset, synchronous, active-low
flush  input  1  discard all entries and the same-cycle input
in_valid  input  1  fetch presents an instruction
in_ready  output  1  queue can accept; a push occurs when in_valid & in_ready
in_inst  input  XLEN  fetched instruction
in_pc  input  XLEN  PC of in_inst
out_valid  output  1  head entry valid (replaces is_a_inst_out)
out_ready  input  1  decode consumes the head; a pop occurs when out_valid & out_ready
out_inst  output  XLEN  head instruction, or NOP_INST when out_valid=0
out_pc  output  XLEN  head PC, or 0 when out_valid=0
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- State: storage array[DEPTH] of {inst, pc}, wptr and rptr ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0), count register.
- Reset (nrst=0 at posedge): wptr=rptr=0, count=0. Storage contents are don't-care. Resulting outputs: out_valid=0, out_inst=NOP_INST, out_pc=0, in_ready=1, count=0.
- Reset mid-operation discards all entries identically. Reset has priority over flush.
- in_ready = (count != DEPTH). It is combinational from registers only and never depends on out_ready, so a full queue does not accept a push even when a pop happens in the same cycle.
- out_valid = (count != 0). out_inst/out_pc come from array[rptr] when valid, else NOP_INST/0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle). There is no fall-through unless FD_QUEUE_BYPASS_EN is defined.
- Push only: write array[wptr], wptr++, count++.
- Pop only: rptr++, count--.
- Push and pop in the same cycle (count 1..DEPTH-1): both pointers advance, count unchanged.
- Empty: pop impossible (out_valid=0), out_ready is ignored.
- Full: push impossible, in_valid is ignored, data is not written.
- flush=1 (priority over push/pop): wptr=rptr=0, count=0. The same-cycle in_valid entry is dropped. Next cycle out_valid=0 and out_inst=NOP_INST.
- Order: FIFO. Entries are never reordered or duplicated.
- Decoder stall maps to out_ready=0; the head is held stable while out_valid=1 & out_ready=0.

Optional Feature:
FD_QUEUE_BYPASS_EN defined:
- When count==0 & in_valid & ~flush, the outputs combinationally present in_inst/in_pc with out_valid=1 (zero-latency fall-through).
- If out_ready=1 in that cycle, the entry is consumed and not written (count stays 0).
- Otherwise it is written normally.

FD_QUEUE_BYPASS_EN undefined:
- The outputs are purely register-driven, with the one-cycle latency above.

Decomposition:
- Package fd_pkg: NOP_INST constant, default XLEN, typedef struct packed fd_entry_t {inst, pc}.
- Sub-module fd_queue_ctrl: owns the pointers and count, and generates in_ready, out_valid, push_en, pop_en and the write/read indices.
- The top level holds the storage array, the output muxing and the bypass path.

Test Plan:
- Reset then idle, in_valid=0 -> out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1, count=0.
- Push pc=0x100/0x104/0x108/0x10C with out_ready=0 (DEPTH=4) -> count=4, in_ready=0. A fifth push (pc=0x110) is ignored. Draining then yields 0x100, 0x104, 0x108, 0x10C, 0x110 never appears.
- Continuous in_valid=out_ready=1 for 20 cycles with incrementing PCs -> count holds at 1. Output PCs are strictly sequential with one-cycle latency, covering pointer wrap.
- Queue holding 3 entries, flush=1 together with in_valid=1 (pc=0x200) -> next cycle count=0, out_valid=0, out_inst=NOP. The 0x200 entry is never output.
- Full queue with out_ready=1 and in_valid=1 in the same cycle -> one pop, no push, count=3.
- FD_QUEUE_BYPASS_EN, empty queue, in_valid=1 pc=0x300, out_ready=1 -> out_valid=1 and out_pc=0x300 in the same cycle, count stays 0.
